// File: rtl/w5300_pkg.sv
// Shared definitions for the w5300 transmit front end: FSM encoding,
// address/port widths and the "no error" code from w5300_entry.
package w5300_pkg;

  localparam int IP_W   = 32;
  localparam int PORT_W = 16;

  localparam logic [2:0] ERR_OK = 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARB        = 3'd1,
    ST_LOAD       = 3'd2,
    ST_ISSUE      = 3'd3,
    ST_WAIT_START = 3'd4,
    ST_WAIT_END   = 3'd5,
    ST_FINISH     = 3'd6
  } state_e;

  // Index following idx in a ring of num_ch entries.
  function automatic int next_index(input int idx, input int num_ch);
    return (idx >= num_ch - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr_i,
// wrapping modulo NUM_CH, is returned as a one-hot grant and as an index.
module rr_arbiter
  import w5300_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);

  // Scan the ring starting at the pointer; the first hit wins.
  always_comb begin
    int c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (int'(ptr_i) + k) % NUM_CH;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/w5300_tx_arbiter.sv
// N-channel transmit front end for w5300_entry. Round-robin arbitration
// serialises channel requests onto the single tx interface, and each
// transfer ends with a one-cycle done (plus err on failure) to its channel.
module w5300_tx_arbiter
  import w5300_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int TX_ADDR_WIDTH = 12,
  parameter int SIZE_WIDTH    = 32,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH*IP_W-1:0]       ch_dest_ip,
  input  logic [NUM_CH*PORT_W-1:0]     ch_dest_port,
  input  logic [NUM_CH*SIZE_WIDTH-1:0] ch_size,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_tx_data,
  output logic [TX_ADDR_WIDTH-1:0]     ch_buf_addr,
  output logic [NUM_CH-1:0]            ch_grant,
  output logic [NUM_CH-1:0]            ch_done,
  output logic [NUM_CH-1:0]            ch_err,
  output logic                         tx_req,
  output logic [IP_W-1:0]              dest_ip,
  output logic [PORT_W-1:0]            dest_port,
  output logic [SIZE_WIDTH-1:0]        tx_data_size,
  output logic [DATA_WIDTH-1:0]        tx_data,
  input  logic [TX_ADDR_WIDTH-1:0]     tx_buffer_addr,
  input  logic                         busy_n,
  input  logic [2:0]                   err_code,
  output logic                         active
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  // The timeout fires on the START_TIMEOUT-th WAIT_START cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [NUM_CH-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    tx_req_q, tx_req_d;
  logic [IP_W-1:0]         ip_q, ip_d;
  logic [PORT_W-1:0]       port_q, port_d;
  logic [SIZE_WIDTH-1:0]   size_q, size_d;

  logic [NUM_CH-1:0]       arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;

  logic [IP_W-1:0]         sel_ip;
  logic [PORT_W-1:0]       sel_port;
  logic [SIZE_WIDTH-1:0]   sel_size;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req_i (ch_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Pick the granted channel's destination and size for loading.
  always_comb begin
    sel_ip   = '0;
    sel_port = '0;
    sel_size = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ip   = ch_dest_ip[i*IP_W +: IP_W];
        sel_port = ch_dest_port[i*PORT_W +: PORT_W];
        sel_size = ch_size[i*SIZE_WIDTH +: SIZE_WIDTH];
      end
    end
  end

  // Payload AND-OR mux on the one-hot grant; zero whenever nothing is granted.
  always_comb begin
    tx_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q[i]) begin
        tx_data = tx_data | ch_tx_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (|ch_req) state_d = ST_ARB;
      // A request that vanished before arbitration is simply not served.
      ST_ARB:        state_d = arb_any ? ST_LOAD : ST_IDLE;
      ST_LOAD:       state_d = (sel_size == '0) ? ST_FINISH : ST_ISSUE;
      ST_ISSUE:      if (busy_n) state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (!busy_n) begin
          state_d = ST_WAIT_END;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FINISH;
        end
      end
      ST_WAIT_END:   if (busy_n) state_d = ST_FINISH;
      ST_FINISH:     state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    ch_done = (state_q == ST_FINISH) ? grant_q : '0;
    ch_err  = (state_q == ST_FINISH && err_q) ? grant_q : '0;
    active  = (state_q != ST_IDLE);
  end

  // Next values for grant, pointer, timeout counter, status and destination.
  always_comb begin
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    tx_req_d = 1'b0;
    ip_d     = ip_q;
    port_d   = port_q;
    size_d   = size_q;
    unique case (state_q)
      ST_ARB: begin
        if (arb_any) begin
          grant_d = arb_gnt;
          idx_d   = arb_idx;
          ptr_d   = IDX_W'(next_index(int'(arb_idx), NUM_CH));
        end
      end
      ST_LOAD: begin
        ip_d   = sel_ip;
        port_d = sel_port;
        size_d = sel_size;
        err_d  = 1'b0;
      end
      ST_ISSUE: begin
        if (busy_n) begin
          tx_req_d = 1'b1;
          cnt_d    = '0;
        end
      end
      ST_WAIT_START: begin
        if (busy_n) begin
          if (cnt_q == CNT_LAST) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT_END: begin
        if (busy_n) err_d = (err_code != ERR_OK);
      end
      ST_FINISH: grant_d = '0;
      default: ;
    endcase
  end

  // Registered control and destination; everything clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q  <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      tx_req_q <= 1'b0;
      ip_q     <= '0;
      port_q   <= '0;
      size_q   <= '0;
    end else begin
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      tx_req_q <= tx_req_d;
      ip_q     <= ip_d;
      port_q   <= port_d;
      size_q   <= size_d;
    end
  end

  assign ch_grant     = grant_q;
  assign tx_req       = tx_req_q;
  assign dest_ip      = ip_q;
  assign dest_port    = port_q;
  assign tx_data_size = size_q;
  assign ch_buf_addr  = tx_buffer_addr;

endmodule

// File: tb/tb_w5300_tx_arbiter.sv
// Bench for w5300_tx_arbiter: directed channel requests push expected
// completions into a scoreboard; a monitor pops and compares on every ch_done.
module tb_w5300_tx_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 16;
  localparam int AW     = 12;
  localparam int SW     = 32;
  localparam int TO     = 64;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_CH-1:0]      ch_req;
  logic [NUM_CH*32-1:0]   ch_dest_ip;
  logic [NUM_CH*16-1:0]   ch_dest_port;
  logic [NUM_CH*SW-1:0]   ch_size;
  logic [NUM_CH*DW-1:0]   ch_tx_data;
  logic [AW-1:0]          ch_buf_addr;
  logic [NUM_CH-1:0]      ch_grant;
  logic [NUM_CH-1:0]      ch_done;
  logic [NUM_CH-1:0]      ch_err;
  logic                   tx_req;
  logic [31:0]            dest_ip;
  logic [15:0]            dest_port;
  logic [SW-1:0]          tx_data_size;
  logic [DW-1:0]          tx_data;
  logic [AW-1:0]          tx_buffer_addr;
  logic                   busy_n;
  logic [2:0]             err_code;
  logic                   active;

  typedef struct {
    int          ch;
    logic        err;
    logic [31:0] ip;
    logic [15:0] port;
    logic [31:0] size;
  } exp_t;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   n_txreq = 0;

  int         model_len      = 8;
  logic [2:0] model_err      = 3'd0;
  bit         model_no_start = 1'b0;

  always #5 clk = ~clk;

  w5300_tx_arbiter #(
    .NUM_CH        (NUM_CH),
    .DATA_WIDTH    (DW),
    .TX_ADDR_WIDTH (AW),
    .SIZE_WIDTH    (SW),
    .START_TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ch_req         (ch_req),
    .ch_dest_ip     (ch_dest_ip),
    .ch_dest_port   (ch_dest_port),
    .ch_size        (ch_size),
    .ch_tx_data     (ch_tx_data),
    .ch_buf_addr    (ch_buf_addr),
    .ch_grant       (ch_grant),
    .ch_done        (ch_done),
    .ch_err         (ch_err),
    .tx_req         (tx_req),
    .dest_ip        (dest_ip),
    .dest_port      (dest_port),
    .tx_data_size   (tx_data_size),
    .tx_data        (tx_data),
    .tx_buffer_addr (tx_buffer_addr),
    .busy_n         (busy_n),
    .err_code       (err_code),
    .active         (active)
  );

  // Each channel answers a buffer read with {channel number, address}.
  always_comb begin
    ch_tx_data = '0;
    for (int i = 0; i < NUM_CH; i++) ch_tx_data[i*DW +: DW] = {4'(i), ch_buf_addr};
  end

  function automatic logic [31:0] ip_of(input int ch);
    return 32'hC0A8_0A01 + 32'(ch);
  endfunction

  function automatic logic [15:0] port_of(input int ch);
    return 16'd5000 + 16'(ch);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(input int ch, input logic [31:0] size, input logic err);
    exp_t e;
    e.ch = ch; e.err = err; e.ip = ip_of(ch); e.port = port_of(ch); e.size = size;
    sb.push_back(e);
  endfunction

  task automatic request(input int ch, input logic [31:0] size, input logic err);
    ch_size[ch*SW +: SW] = size;
    ch_req[ch] = 1'b1;
    push_exp(ch, size, err);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !active && ch_req == '0 && busy_n) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL %s_idle_timeout: still busy after %0d cycles, expected idle", tag, budget);
  endtask

  // w5300_entry stand-in: answers tx_req with a busy window and an error code.
  initial begin
    busy_n = 1'b1; err_code = 3'd0; tx_buffer_addr = '0;
    @(posedge clk); #1;
    forever begin
      if (tx_req === 1'b1) begin
        n_txreq++;
        if (!model_no_start) begin
          repeat (2) @(posedge clk);
          #1 busy_n = 1'b0;
          for (int k = 0; k < model_len; k++) begin
            tx_buffer_addr = AW'(k);
            @(posedge clk); #1;
          end
          busy_n = 1'b1; err_code = model_err; tx_buffer_addr = '0;
          @(posedge clk); #1 err_code = 3'd0;
        end else begin
          @(posedge clk); #1;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // Channels drop their request once they see their done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (ch_done != '0) ch_req = ch_req & ~ch_done;
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ch_done != '0) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: ch_done=0x%0h with nothing outstanding, expected 0x0", ch_done);
        end else begin
          e = sb.pop_front();
          chk("done_onehot",   32'(ch_done),   32'(1) << e.ch);
          chk("err_flag",      32'(ch_err),    e.err ? (32'(1) << e.ch) : 32'd0);
          chk("grant_at_done", 32'(ch_grant),  32'(1) << e.ch);
          chk("dest_ip",       dest_ip,        e.ip);
          chk("dest_port",     32'(dest_port), 32'(e.port));
          chk("tx_data_size",  tx_data_size,   e.size);
        end
      end else if (ch_err != '0) begin
        n_cmp++; n_fail++;
        $display("FAIL err_without_done: ch_err=0x%0h, expected 0x0", ch_err);
      end
      if (ch_grant != '0 && !busy_n && tx_buffer_addr == AW'(5) && sb.size() != 0) begin
        chk("tx_data_mux",   32'(tx_data),     32'({4'(sb[0].ch), 12'd5}));
        chk("buf_addr_pass", 32'(ch_buf_addr), 32'd5);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int lat;
    rst = 1'b1; ch_req = '0; ch_size = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_dest_ip[i*32 +: 32]   = ip_of(i);
      ch_dest_port[i*16 +: 16] = port_of(i);
    end
    repeat (3) @(negedge clk);
    chk("rst_grant",   32'(ch_grant),     32'd0);
    chk("rst_done",    32'(ch_done),      32'd0);
    chk("rst_err",     32'(ch_err),       32'd0);
    chk("rst_txreq",   32'(tx_req),       32'd0);
    chk("rst_ip",      dest_ip,           32'd0);
    chk("rst_port",    32'(dest_port),    32'd0);
    chk("rst_size",    tx_data_size,      32'd0);
    chk("rst_txdata",  32'(tx_data),      32'd0);
    chk("rst_active",  32'(active),       32'd0);
    rst = 1'b0;

    // All four together from pointer 0, then ch0 again behind ch3.
    model_len = 8;
    @(negedge clk); t0 = n_txreq;
    request(0, 32'd4, 1'b0); request(1, 32'd6, 1'b0);
    request(2, 32'd8, 1'b0); request(3, 32'd10, 1'b0);
    lat = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!ch_req[0]) begin lat = 1; break; end
    end
    chk("rr_ch0_dropped", 32'(lat), 32'd1);
    request(0, 32'd2, 1'b0);
    wait_idle(2000, "rr");
    chk("rr_txreq_count", 32'(n_txreq - t0), 32'd5);

    // Single ch1 transfer, 20-cycle busy window, no error.
    model_len = 20;
    @(negedge clk); t0 = n_txreq;
    request(1, 32'd16, 1'b0);
    wait_idle(500, "single");
    chk("single_txreq_count", 32'(n_txreq - t0), 32'd1);

    // Zero-size ch2: done three cycles after the request, no tx_req.
    @(negedge clk); t0 = n_txreq;
    request(2, 32'd0, 1'b0);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ch_done[2]) begin lat = k; break; end
    end
    chk("size0_done_latency", 32'(lat), 32'd3);
    wait_idle(100, "size0");
    chk("size0_txreq_count", 32'(n_txreq - t0), 32'd0);

    // Start timeout on ch3: busy_n never falls.
    model_no_start = 1'b1;
    @(negedge clk); t0 = n_txreq;
    request(3, 32'd32, 1'b1);
    wait_idle(300, "timeout");
    chk("timeout_txreq_count", 32'(n_txreq - t0), 32'd1);
    chk("timeout_active", 32'(active), 32'd0);
    model_no_start = 1'b0;

    // Error code 5 reported at end of transfer on ch0.
    model_len = 6; model_err = 3'd5;
    @(negedge clk);
    request(0, 32'd8, 1'b1);
    wait_idle(300, "errcode");
    model_err = 3'd0;

    // Reset in WAIT_END: pointer is at 1 so ch2 wins first; after reset ch0 wins.
    model_len = 20;
    @(negedge clk);
    ch_size[0*SW +: SW] = 32'd8;
    ch_size[2*SW +: SW] = 32'd12;
    ch_req[0] = 1'b1; ch_req[2] = 1'b1;
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy_n) begin lat = 1; break; end
    end
    chk("rst_mid_busy_seen", 32'(lat), 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_mid_grant_before", 32'(ch_grant), 32'h4);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_grant",  32'(ch_grant),  32'd0);
    chk("rst_mid_active", 32'(active),    32'd0);
    chk("rst_mid_txreq",  32'(tx_req),    32'd0);
    chk("rst_mid_done",   32'(ch_done),   32'd0);
    chk("rst_mid_ip",     dest_ip,        32'd0);
    chk("rst_mid_size",   tx_data_size,   32'd0);
    push_exp(0, 32'd8, 1'b0);
    push_exp(2, 32'd12, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle(1000, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
